// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: N-channel alarm controller for the math alarm clock.
// Stores NUM_ALARMS alarm times with per-channel enables, edited through the
// set switch and keys. Each channel is compared against the running clock time
// and drives one ring output plus the id of the channel that fired.
// Optional feature macro: SNOOZE_EN adds the snooze port and SNOOZE state.
module multi_alarm_ctrl #(
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = 2,
    parameter int HR_W       = 4,
    parameter int HR_FIRST   = 1,
    parameter int HR_LAST    = 12,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alarm_set,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  hr_key,
    input  logic                  min_key,
    input  logic                  en_key,
    input  logic [HR_W-1:0]       clock_hr,
    input  logic [5:0]            clock_min,
    input  logic                  alarm_off,
`ifdef SNOOZE_EN
    input  logic                  snooze,
`endif
    output logic [HR_W-1:0]       alarm_hr,
    output logic [5:0]            alarm_min,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic                  alarm,
    output logic [SEL_W-1:0]      active_id
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RING   = 2'd1;
`ifdef SNOOZE_EN
    localparam logic [1:0] SNOOZE = 2'd2;
`endif

    // Reject configurations the channel select or snooze arithmetic cannot represent.
    if (NUM_ALARMS < 1 || NUM_ALARMS > 16 || (1 << SEL_W) < NUM_ALARMS ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_param_check
        $error("multi_alarm_ctrl: illegal parameter combination");
    end

    logic [HR_W-1:0]       hr_q [NUM_ALARMS];
    logic [5:0]            min_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q;
    logic [NUM_ALARMS-1:0] fired_q;
    logic [NUM_ALARMS-1:0] fired_d;
    logic [1:0]            state_q;
    logic [SEL_W-1:0]      active_q;
    logic                  hr_key_q;
    logic                  min_key_q;
    logic                  en_key_q;
    logic                  off_q;
    logic [5:0]            min_prev_q;
    logic                  hr_edge;
    logic                  min_edge;
    logic                  en_edge;
    logic                  off_edge;
    logic                  edit_ok;
    logic                  dismiss;
    logic                  match_any;
    logic [SEL_W-1:0]      match_id;
    logic [31:0]           sel_ext;

    assign sel_ext  = 32'(sel);
    assign hr_edge  = hr_key & ~hr_key_q;
    assign min_edge = min_key & ~min_key_q;
    assign en_edge  = en_key & ~en_key_q;
    assign off_edge = alarm_off & ~off_q;
    assign edit_ok  = alarm_set && (state_q == IDLE);
    assign dismiss  = off_edge && (state_q != IDLE);

`ifdef SNOOZE_EN
    logic            snooze_q;
    logic            snooze_edge;
    logic [6:0]      snz_sum;
    logic            snz_carry;
    logic [5:0]      snz_min_d;
    logic [HR_W-1:0] snz_hr_d;
    logic [5:0]      tgt_min_q;
    logic [HR_W-1:0] tgt_hr_q;

    assign snooze_edge = snooze & ~snooze_q;
    assign snz_sum     = {1'b0, clock_min} + 7'(SNOOZE_MIN);
    assign snz_carry   = (snz_sum >= 7'd60);

    // Snooze target is the current time plus SNOOZE_MIN, carrying into the hour on minute wrap.
    always_comb begin
        snz_min_d = snz_carry ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
        snz_hr_d  = clock_hr;
        if (snz_carry) begin
            snz_hr_d = (clock_hr == HR_W'(HR_LAST)) ? HR_W'(HR_FIRST) : clock_hr + HR_W'(1);
        end
    end
`endif

    // Lowest-index enabled, not-yet-fired channel whose time equals the clock.
    always_comb begin
        match_any = 1'b0;
        match_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && !fired_q[i] && (hr_q[i] == clock_hr) && (min_q[i] == clock_min)) begin
                match_any = 1'b1;
                match_id  = SEL_W'(i);
            end
        end
    end

    // Fired flags reset on every minute change; a dismissed channel is marked so it cannot re-ring this minute.
    always_comb begin
        fired_d = (clock_min != min_prev_q) ? '0 : fired_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (dismiss && (32'(active_q) == i)) begin
                fired_d[i] = 1'b1;
            end
        end
    end

    // Expose the selected channel's time; out-of-range selects read back as zero.
    always_comb begin
        alarm_hr  = '0;
        alarm_min = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_ext == i) begin
                alarm_hr  = hr_q[i];
                alarm_min = min_q[i];
            end
        end
    end

    // Channel storage, key edge detectors, fired tracking and the ring state machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                hr_q[i]  <= HR_W'(HR_FIRST);
                min_q[i] <= '0;
            end
            en_q       <= '0;
            fired_q    <= '0;
            state_q    <= IDLE;
            active_q   <= '0;
            hr_key_q   <= 1'b0;
            min_key_q  <= 1'b0;
            en_key_q   <= 1'b0;
            off_q      <= 1'b0;
            min_prev_q <= '0;
`ifdef SNOOZE_EN
            snooze_q   <= 1'b0;
            tgt_min_q  <= '0;
            tgt_hr_q   <= '0;
`endif
        end else begin
            hr_key_q   <= hr_key;
            min_key_q  <= min_key;
            en_key_q   <= en_key;
            off_q      <= alarm_off;
            min_prev_q <= clock_min;
            fired_q    <= fired_d;
`ifdef SNOOZE_EN
            snooze_q   <= snooze;
`endif
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (edit_ok && (sel_ext == i)) begin
                    if (hr_edge) begin
                        hr_q[i] <= (hr_q[i] == HR_W'(HR_LAST)) ? HR_W'(HR_FIRST) : hr_q[i] + HR_W'(1);
                    end
                    if (min_edge) begin
                        min_q[i] <= (min_q[i] == 6'd59) ? 6'd0 : min_q[i] + 6'd1;
                    end
                    if (en_edge) begin
                        en_q[i] <= ~en_q[i];
                    end
                end
            end
            case (state_q)
                IDLE: begin
                    if (!alarm_set && match_any) begin
                        state_q  <= RING;
                        active_q <= match_id;
                    end
                end
                RING: begin
                    if (off_edge) begin
                        state_q <= IDLE;
`ifdef SNOOZE_EN
                    end else if (snooze_edge) begin
                        state_q   <= SNOOZE;
                        tgt_min_q <= snz_min_d;
                        tgt_hr_q  <= snz_hr_d;
`endif
                    end
                end
`ifdef SNOOZE_EN
                SNOOZE: begin
                    if (off_edge) begin
                        state_q <= IDLE;
                    end else if ((clock_hr == tgt_hr_q) && (clock_min == tgt_min_q)) begin
                        state_q <= RING;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alarm     = (state_q == RING);
    assign active_id = active_q;
    assign alarm_en  = en_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed bench for multi_alarm_ctrl with a reference model.
// Build with SNOOZE_EN defined to also exercise the snooze sequence.
module tb_multi_alarm_ctrl;

    localparam int NUM      = 4;
    localparam int HR_FIRST = 1;
    localparam int HR_LAST  = 12;
    localparam int SNZ      = 5;

    logic       clock;
    logic       reset;
    logic       alarm_set;
    logic [1:0] sel;
    logic       hr_key;
    logic       min_key;
    logic       en_key;
    logic [3:0] clock_hr;
    logic [5:0] clock_min;
    logic       alarm_off;
    logic       snooze;
    logic [3:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [3:0] alarm_en;
    logic       alarm;
    logic [1:0] active_id;

    int checks = 0;
    int passes = 0;

    multi_alarm_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .alarm_set (alarm_set),
        .sel       (sel),
        .hr_key    (hr_key),
        .min_key   (min_key),
        .en_key    (en_key),
        .clock_hr  (clock_hr),
        .clock_min (clock_min),
        .alarm_off (alarm_off),
`ifdef SNOOZE_EN
        .snooze    (snooze),
`endif
        .alarm_hr  (alarm_hr),
        .alarm_min (alarm_min),
        .alarm_en  (alarm_en),
        .alarm     (alarm),
        .active_id (active_id)
    );

    // Free-running 100 MHz style clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it disagrees.
    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference model: alarm times as plain integers, ring status as 0 idle / 1 ringing / 2 snoozed.
    int m_hr [NUM];
    int m_min [NUM];
    bit [NUM-1:0] m_en;
    bit [NUM-1:0] m_fired;
    int m_state;
    int m_active;
    int m_tgt_hr;
    int m_tgt_min;
    bit p_hr, p_min_key, p_en, p_off, p_snz;
    int p_min;

    // Advance the model one clock using the same input values the design sees.
    always @(posedge clock) begin
        bit e_hr, e_min, e_en, e_off, e_snz;
        int hit;
        bit [NUM-1:0] nf;
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                m_hr[i] = HR_FIRST;
                m_min[i] = 0;
            end
            m_en = '0; m_fired = '0; m_state = 0; m_active = 0;
            p_hr = 0; p_min_key = 0; p_en = 0; p_off = 0; p_snz = 0; p_min = 0;
        end else begin
            e_hr  = hr_key && !p_hr;
            e_min = min_key && !p_min_key;
            e_en  = en_key && !p_en;
            e_off = alarm_off && !p_off;
            e_snz = snooze && !p_snz;
            hit = -1;
            for (int i = NUM - 1; i >= 0; i--)
                if (m_en[i] && !m_fired[i] && m_hr[i] == int'(clock_hr) && m_min[i] == int'(clock_min))
                    hit = i;
            nf = (int'(clock_min) != p_min) ? '0 : m_fired;
            if (m_state == 0) begin
                if (alarm_set) begin
                    if (int'(sel) < NUM) begin
                        if (e_hr)  m_hr[sel]  = (m_hr[sel] == HR_LAST) ? HR_FIRST : m_hr[sel] + 1;
                        if (e_min) m_min[sel] = (m_min[sel] + 1) % 60;
                        if (e_en)  m_en[sel]  = !m_en[sel];
                    end
                end else if (hit >= 0) begin
                    m_state = 1;
                    m_active = hit;
                end
            end else if (e_off) begin
                m_state = 0;
                nf[m_active] = 1'b1;
            end else if (m_state == 1) begin
`ifdef SNOOZE_EN
                if (e_snz) begin
                    m_state = 2;
                    m_tgt_min = (int'(clock_min) + SNZ) % 60;
                    m_tgt_hr = int'(clock_hr);
                    if (int'(clock_min) + SNZ >= 60)
                        m_tgt_hr = (m_tgt_hr == HR_LAST) ? HR_FIRST : m_tgt_hr + 1;
                end
`endif
            end else if (m_tgt_hr == int'(clock_hr) && m_tgt_min == int'(clock_min)) begin
                m_state = 1;
            end
            m_fired = nf;
            p_hr = hr_key; p_min_key = min_key; p_en = en_key; p_off = alarm_off;
            p_snz = snooze; p_min = int'(clock_min);
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        check_output("alarm", int'(alarm), (m_state == 1) ? 1 : 0);
        if (m_state == 1) check_output("active_id", int'(active_id), m_active);
        check_output("alarm_en", int'(alarm_en), int'(m_en));
        check_output("alarm_hr", int'(alarm_hr), (int'(sel) < NUM) ? m_hr[sel] : 0);
        check_output("alarm_min", int'(alarm_min), (int'(sel) < NUM) ? m_min[sel] : 0);
    end

    // Let n rising edges pass, leaving inputs safely away from the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Press and release one key (0 hr, 1 min, 2 en, 3 off, 4 snooze) count times.
    task automatic apply_stimulus(input int which, input int count);
        for (int k = 0; k < count; k++) begin
            case (which)
                0: hr_key = 1'b1;
                1: min_key = 1'b1;
                2: en_key = 1'b1;
                3: alarm_off = 1'b1;
                default: snooze = 1'b1;
            endcase
            step(1);
            hr_key = 1'b0; min_key = 1'b0; en_key = 1'b0; alarm_off = 1'b0; snooze = 1'b0;
            step(1);
        end
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        reset = 1'b1; alarm_set = 1'b0; sel = 2'd0; hr_key = 1'b0; min_key = 1'b0;
        en_key = 1'b0; clock_hr = 4'd1; clock_min = 6'd0; alarm_off = 1'b0; snooze = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        check_output("reset alarm", int'(alarm), 0);
        check_output("reset enables", int'(alarm_en), 0);
        check_output("reset hour", int'(alarm_hr), 1);
        check_output("reset minute", int'(alarm_min), 0);

        $display("[TB] edit channel 2");
        alarm_set = 1'b1; sel = 2'd2;
        apply_stimulus(0, 3);
        apply_stimulus(1, 2);
        apply_stimulus(2, 1);
        check_output("edit hour", int'(alarm_hr), 4);
        check_output("edit minute", int'(alarm_min), 2);
        check_output("edit enable", int'(alarm_en), 4);

        $display("[TB] channel 2 rings at 4:02");
        clock_hr = 4'd4; clock_min = 6'd1; alarm_set = 1'b0;
        step(2);
        check_output("before match", int'(alarm), 0);
        clock_min = 6'd2;
        check_output("match same cycle", int'(alarm), 0);
        step(1);
        check_output("ring ch2", int'(alarm), 1);
        check_output("ring ch2 id", int'(active_id), 2);
        apply_stimulus(3, 1);
        step(4);
        check_output("no re-ring same minute", int'(alarm), 0);
        clock_min = 6'd3;
        step(1);
        clock_min = 6'd2;
        step(1);
        check_output("re-ring after minute change", int'(alarm), 1);
        apply_stimulus(3, 1);

        $display("[TB] channels 0 and 3 at 7:30");
        alarm_set = 1'b1; clock_hr = 4'd7; clock_min = 6'd29;
        for (int c = 0; c < 4; c += 3) begin
            sel = 2'(c);
            apply_stimulus(0, 6);
            apply_stimulus(1, 30);
            apply_stimulus(2, 1);
        end
        check_output("enables 0,2,3", int'(alarm_en), 13);
        alarm_set = 1'b0;
        step(2);
        clock_min = 6'd30;
        step(1);
        check_output("ring lowest", int'(active_id), 0);
        alarm_off = 1'b1;
        step(1);
        check_output("dismiss ch0", int'(alarm), 0);
        step(1);
        check_output("ch3 follows", int'(alarm), 1);
        check_output("ch3 id", int'(active_id), 3);
        alarm_off = 1'b0;
        step(1);
        apply_stimulus(3, 1);
        check_output("dismiss ch3", int'(alarm), 0);

        $display("[TB] wrap and held key on channel 1");
        alarm_set = 1'b1; sel = 2'd1;
        apply_stimulus(0, 11);
        check_output("hour 12", int'(alarm_hr), 12);
        apply_stimulus(0, 1);
        check_output("hour wraps to 1", int'(alarm_hr), 1);
        apply_stimulus(1, 59);
        check_output("minute 59", int'(alarm_min), 59);
        apply_stimulus(1, 1);
        check_output("minute wraps to 0", int'(alarm_min), 0);
        check_output("no hour carry", int'(alarm_hr), 1);
        min_key = 1'b1;
        step(1000);
        min_key = 1'b0;
        step(1);
        check_output("held key once", int'(alarm_min), 1);

        $display("[TB] reset while ringing");
        alarm_set = 1'b0; clock_min = 6'd31;
        step(1);
        clock_min = 6'd30;
        step(1);
        check_output("ring before reset", int'(alarm), 1);
        reset = 1'b1;
        step(1);
        check_output("reset stops ring", int'(alarm), 0);
        check_output("reset clears enables", int'(alarm_en), 0);
        reset = 1'b0;
        step(3);
        check_output("no ring after reset", int'(alarm), 0);

`ifdef SNOOZE_EN
        $display("[TB] snooze across hour wrap");
        alarm_set = 1'b1; sel = 2'd0; clock_hr = 4'd12; clock_min = 6'd57;
        apply_stimulus(0, 11);
        apply_stimulus(1, 58);
        apply_stimulus(2, 1);
        alarm_set = 1'b0;
        step(1);
        clock_min = 6'd58;
        step(1);
        check_output("snooze ring", int'(alarm), 1);
        apply_stimulus(4, 1);
        check_output("snoozed quiet", int'(alarm), 0);
        clock_hr = 4'd1; clock_min = 6'd2;
        step(3);
        check_output("before target", int'(alarm), 0);
        clock_min = 6'd3;
        step(1);
        check_output("snooze re-ring", int'(alarm), 1);
        check_output("snooze id", int'(active_id), 0);
        apply_stimulus(3, 1);
        check_output("snooze dismissed", int'(alarm), 0);
`endif

        step(2);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
